// File: rtl/truth_table_sweeper_if.sv
// Bus bundle between a truth-table sweeper and the bench/DUT harness around it.
// The slave modport is the sweeper; the master modport drives requests and responses.
interface truth_table_sweeper_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3
);
   logic             start;
   logic             abort;
   logic [N_OUT-1:0] dut_out;
   logic [N_OUT-1:0] gold_out;
   logic [N_IN-1:0]  vec_out;
   logic             row_valid;
   logic [N_IN-1:0]  row_idx;
   logic             row_mismatch;
   logic [N_IN:0]    mismatch_cnt;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, dut_out, gold_out,
      input  vec_out, row_valid, row_idx, row_mismatch, mismatch_cnt, busy, done
   );

   modport slave (
      input  start, abort, dut_out, gold_out,
      output vec_out, row_valid, row_idx, row_mismatch, mismatch_cnt, busy, done
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector, waits SETTLE cycles,
// compares the DUT response against the golden response and counts mismatches.
module truth_table_sweeper #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 3,
   parameter int SETTLE = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   truth_table_sweeper_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [N_IN:0] LAST_ROW = (N_IN+1)'((1 << N_IN) - 1);
   localparam logic [7:0]    WAIT_LD  = 8'(SETTLE);

   state_t            state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic [N_IN:0]     row_q, row_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic              row_valid_q, row_valid_d;
   logic [N_IN-1:0]   row_idx_q, row_idx_d;
   logic              row_mismatch_q, row_mismatch_d;
   logic [N_IN:0]     mis_cnt_q, mis_cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              mismatch;

   assign mismatch = (bus.dut_out != bus.gold_out);

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      row_d          = row_q;
      vec_d          = vec_q;
      row_valid_d    = 1'b0;
      row_idx_d      = row_idx_q;
      row_mismatch_d = row_mismatch_q;
      mis_cnt_d      = mis_cnt_q;

      // abort outranks start in every state; the partial count is kept
      if (bus.abort) begin
         state_d = S_IDLE;
         vec_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state_d   = S_SETTLE;
                  row_d     = '0;
                  vec_d     = '0;
                  mis_cnt_d = '0;
                  wait_d    = WAIT_LD;
               end
            end
            S_SETTLE: begin
               if (wait_q <= 8'd1) begin
                  state_d = S_SAMPLE;
               end else begin
                  wait_d = wait_q - 8'd1;
               end
            end
            S_SAMPLE: begin
               row_valid_d    = 1'b1;
               row_idx_d      = row_q[N_IN-1:0];
               row_mismatch_d = mismatch;
               mis_cnt_d      = mis_cnt_q + {{N_IN{1'b0}}, mismatch};
               if (row_q == LAST_ROW) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SETTLE;
                  row_d   = row_q + (N_IN+1)'(1);
                  vec_d   = vec_q + N_IN'(1);
                  wait_d  = WAIT_LD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // status flags follow the next state so they are registered with it
      busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         wait_q         <= '0;
         row_q          <= '0;
         vec_q          <= '0;
         row_valid_q    <= 1'b0;
         row_idx_q      <= '0;
         row_mismatch_q <= 1'b0;
         mis_cnt_q      <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_q         <= wait_d;
         row_q          <= row_d;
         vec_q          <= vec_d;
         row_valid_q    <= row_valid_d;
         row_idx_q      <= row_idx_d;
         row_mismatch_q <= row_mismatch_d;
         mis_cnt_q      <= mis_cnt_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign bus.vec_out      = vec_q;
   assign bus.row_valid    = row_valid_q;
   assign bus.row_idx      = row_idx_q;
   assign bus.row_mismatch = row_mismatch_q;
   assign bus.mismatch_cnt = mis_cnt_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a 4-input sweeper with a small combinational DUT model, plus a
// 1-input, SETTLE=1 sweeper for the smallest-table boundary.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst_n;
   logic inject;
   logic allmis;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(4), .N_OUT(3)) bus4 ();
   truth_table_sweeper_if #(.N_IN(1), .N_OUT(1)) bus1 ();

   truth_table_sweeper #(.N_IN(4), .N_OUT(3), .SETTLE(2)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   truth_table_sweeper #(.N_IN(1), .N_OUT(1), .SETTLE(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // DUT model: parity, AND of the two low bits, OR of the two high bits
   logic [2:0] resp4;
   always_comb begin
      resp4 = {^bus4.vec_out, bus4.vec_out[0] & bus4.vec_out[1],
               bus4.vec_out[3] | bus4.vec_out[2]};
      bus4.dut_out  = resp4;
      bus4.gold_out = (inject && (bus4.vec_out == 4'd5 || bus4.vec_out == 4'd12))
                      ? (resp4 ^ 3'b010) : resp4;
      bus1.dut_out  = bus1.vec_out;
      bus1.gold_out = allmis ? ~bus1.vec_out : bus1.vec_out;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller raises start at a drive point; this consumes the accept edge and
   // checks the full 48-cycle sweep of the 4-input instance.
   task automatic run_full_sweep(input bit inj, input bit hold_start, input string tag);
      int pulses;
      int exp_vec;
      bit exp_valid;
      bit exp_done;
      bit exp_mis;
      pulses = 0;
      tick();
      if (!hold_start) bus4.start = 1'b0;
      checks++;
      if (bus4.busy !== 1'b1 || bus4.vec_out !== 4'd0 || bus4.done !== 1'b0 ||
          bus4.mismatch_cnt !== 5'd0) begin
         errors++;
         $display("FAIL %s accept: busy=%0b vec=%0d done=%0b cnt=%0d expected 1/0/0/0",
                  tag, bus4.busy, bus4.vec_out, bus4.done, bus4.mismatch_cnt);
      end
      for (int k = 1; k <= 50; k++) begin
         if (hold_start && k == 47) bus4.start = 1'b0;
         tick();
         exp_valid = (k % 3 == 0) && (k <= 48);
         exp_done  = (k >= 48);
         exp_vec   = (k >= 48) ? 15 : k / 3;
         exp_mis   = inj && ((k / 3 - 1) == 5 || (k / 3 - 1) == 12);
         if (bus4.row_valid === 1'b1) pulses++;
         checks++;
         if (bus4.row_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s row_valid cycle %0d: got %0b expected %0b",
                     tag, k, bus4.row_valid, exp_valid);
         end
         if (exp_valid) begin
            checks++;
            if (bus4.row_idx !== 4'(k / 3 - 1) || bus4.row_mismatch !== exp_mis) begin
               errors++;
               $display("FAIL %s row cycle %0d: idx=%0d mis=%0b expected idx=%0d mis=%0b",
                        tag, k, bus4.row_idx, bus4.row_mismatch, k / 3 - 1, exp_mis);
            end
         end
         checks++;
         if (bus4.vec_out !== 4'(exp_vec) || bus4.done !== exp_done ||
             bus4.busy !== !exp_done) begin
            errors++;
            $display("FAIL %s state cycle %0d: vec=%0d done=%0b busy=%0b expected vec=%0d done=%0b busy=%0b",
                     tag, k, bus4.vec_out, bus4.done, bus4.busy, exp_vec, exp_done, !exp_done);
         end
      end
      checks++;
      if (pulses != 16) begin
         errors++;
         $display("FAIL %s pulse count: got %0d expected 16", tag, pulses);
      end
      checks++;
      if (bus4.mismatch_cnt !== 5'(inj ? 2 : 0) || bus4.row_idx !== 4'd15) begin
         errors++;
         $display("FAIL %s final: cnt=%0d idx=%0d expected cnt=%0d idx=15",
                  tag, bus4.mismatch_cnt, bus4.row_idx, inj ? 2 : 0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus4.start = 1'b0; bus4.abort = 1'b0;
      bus1.start = 1'b0; bus1.abort = 1'b0;
      inject = 1'b0; allmis = 1'b0;
      #2;
      checks++;
      if ({bus4.vec_out, bus4.row_valid, bus4.row_idx, bus4.row_mismatch,
           bus4.mismatch_cnt, bus4.busy, bus4.done} !== '0 ||
          {bus1.vec_out, bus1.row_valid, bus1.busy, bus1.done, bus1.mismatch_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_initial: vec=%0d busy=%0b done=%0b cnt=%0d expected all 0",
                  bus4.vec_out, bus4.busy, bus4.done, bus4.mismatch_cnt);
      end
      #1 rst_n = 1'b1;
      tick();
      checks++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%0b done=%0b expected 0/0", bus4.busy, bus4.done);
      end
      inject = 1'b1;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      repeat (20) tick();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus4.vec_out, bus4.row_valid, bus4.row_idx, bus4.row_mismatch,
           bus4.mismatch_cnt, bus4.busy, bus4.done} !== '0) begin
         errors++;
         $display("FAIL reset_midsweep: vec=%0d idx=%0d busy=%0b cnt=%0d expected all 0",
                  bus4.vec_out, bus4.row_idx, bus4.busy, bus4.mismatch_cnt);
      end
      #2 rst_n = 1'b1;
      inject = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.vec_out !== 4'd0) begin
         errors++;
         $display("FAIL reset_stays_idle: busy=%0b done=%0b vec=%0d expected 0/0/0",
                  bus4.busy, bus4.done, bus4.vec_out);
      end
   endtask

   task automatic test_loopback();
      inject = 1'b0;
      bus4.start = 1'b1;
      run_full_sweep(1'b0, 1'b0, "loopback");
   endtask

   task automatic test_injected();
      inject = 1'b1;
      bus4.start = 1'b1;
      run_full_sweep(1'b1, 1'b0, "injected");
      inject = 1'b0;
   endtask

   task automatic test_abort();
      bit found;
      found = 1'b0;
      inject = 1'b1;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus4.vec_out === 4'd7) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL abort_reach_row7: vec=%0d expected 7 within 100 cycles", bus4.vec_out);
      end
      bus4.abort = 1'b1;
      bus4.start = 1'b1;
      tick();
      checks++;
      if (bus4.busy !== 1'b0 || bus4.vec_out !== 4'd0 || bus4.done !== 1'b0 ||
          bus4.row_valid !== 1'b0 || bus4.mismatch_cnt !== 5'd1) begin
         errors++;
         $display("FAIL abort_effect: busy=%0b vec=%0d done=%0b rv=%0b cnt=%0d expected 0/0/0/0/1",
                  bus4.busy, bus4.vec_out, bus4.done, bus4.row_valid, bus4.mismatch_cnt);
      end
      bus4.abort = 1'b0;
      bus4.start = 1'b0;
      tick();
      checks++;
      if (bus4.busy !== 1'b0 || bus4.mismatch_cnt !== 5'd1) begin
         errors++;
         $display("FAIL abort_idle: busy=%0b cnt=%0d expected 0/1", bus4.busy, bus4.mismatch_cnt);
      end
      bus4.start = 1'b1;
      run_full_sweep(1'b1, 1'b0, "after_abort");
      inject = 1'b0;
   endtask

   task automatic test_start_handling();
      inject = 1'b1;
      bus4.start = 1'b1;
      run_full_sweep(1'b1, 1'b1, "start_held");
      inject = 1'b0;
      bus4.start = 1'b1;
      run_full_sweep(1'b0, 1'b0, "restart_done");
   endtask

   task automatic test_boundary();
      bit exp_valid;
      bit exp_done;
      allmis = 1'b1;
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      checks++;
      if (bus1.busy !== 1'b1 || bus1.vec_out !== 1'b0) begin
         errors++;
         $display("FAIL boundary_accept: busy=%0b vec=%0d expected 1/0", bus1.busy, bus1.vec_out);
      end
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_valid = (k % 2 == 0) && (k <= 4);
         exp_done  = (k >= 4);
         checks++;
         if (bus1.row_valid !== exp_valid || bus1.done !== exp_done) begin
            errors++;
            $display("FAIL boundary cycle %0d: rv=%0b done=%0b expected rv=%0b done=%0b",
                     k, bus1.row_valid, bus1.done, exp_valid, exp_done);
         end
         if (exp_valid) begin
            checks++;
            if (bus1.row_idx !== 1'(k / 2 - 1) || bus1.row_mismatch !== 1'b1) begin
               errors++;
               $display("FAIL boundary row cycle %0d: idx=%0d mis=%0b expected idx=%0d mis=1",
                        k, bus1.row_idx, bus1.row_mismatch, k / 2 - 1);
            end
         end
      end
      checks++;
      if (bus1.mismatch_cnt !== 2'd2) begin
         errors++;
         $display("FAIL boundary_count: cnt=%0d expected 2", bus1.mismatch_cnt);
      end
      allmis = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_injected();
      test_abort();
      test_start_handling();
      test_boundary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of DUT inputs driven; legal range 1..16.
REQ-002 SHALL have parameter N_OUT, default 3: number of DUT outputs checked; legal range 1..32.
REQ-003 SHALL have parameter SETTLE, default 2: cycles a vector is held before sampling; legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: sweep request, sampled on each rising edge.
REQ-007 SHALL have port abort, input, 1 bit: synchronous sweep cancel.
REQ-008 SHALL have port dut_out, input, N_OUT bits: DUT response to vec_out.
REQ-009 SHALL have port gold_out, input, N_OUT bits: expected response for the current vector.
REQ-010 SHALL have port vec_out, output, N_IN bits: stimulus vector, registered.
REQ-011 SHALL have port row_valid, output, 1 bit: one-cycle pulse when a row result is published.
REQ-012 SHALL have port row_idx, output, N_IN bits: index of the published row.
REQ-013 SHALL have port row_mismatch, output, 1 bit: published row had dut_out != gold_out.
REQ-014 SHALL have port mismatch_cnt, output, N_IN+1 bits: mismatching rows counted in the current or last sweep.
REQ-015 SHALL have port busy, output, 1 bit: high in SETTLE and SAMPLE states.
REQ-016 SHALL have port done, output, 1 bit: high in DONE state.

Function
REQ-017 SHALL implement states IDLE, SETTLE, SAMPLE and DONE; all outputs registered.
REQ-018 In IDLE or DONE, start=1 with abort=0 SHALL clear row counter, vec_out, mismatch_cnt and done, load wait counter with SETTLE, and enter SETTLE.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL hold SETTLE for exactly SETTLE cycles, with vec_out stable, then enter SAMPLE.
REQ-021 SAMPLE SHALL last one cycle and compare dut_out against gold_out as presented during that cycle.
REQ-022 On the edge leaving SAMPLE, SHALL set row_valid=1, row_idx=current row and row_mismatch=(dut_out!=gold_out), and SHALL increment mismatch_cnt by row_mismatch.
REQ-023 row_valid SHALL be 0 in every cycle other than the one immediately following SAMPLE.
REQ-024 On leaving SAMPLE with row < 2^N_IN-1, SHALL increment row and vec_out and re-enter SETTLE with the wait counter reloaded.
REQ-025 On leaving SAMPLE with row = 2^N_IN-1, SHALL enter DONE, and vec_out SHALL hold its last value.
REQ-026 Row counter SHALL be N_IN+1 bits wide, so the terminal compare never wraps; mismatch_cnt (maximum 2^N_IN) SHALL never overflow.
REQ-027 A full sweep SHALL take 2^N_IN*(SETTLE+1) cycles from the start-accept edge to the DONE-entry edge.
REQ-028 DONE SHALL hold done=1, with mismatch_cnt, row_idx and vec_out frozen, until the next accepted start.
REQ-029 abort=1 in any state SHALL force IDLE on the next edge and clear vec_out, busy, done and row_valid; mismatch_cnt SHALL hold its partial value.
REQ-030 abort and start asserted together SHALL resolve in favour of abort.
REQ-031 A start accepted in DONE SHALL restart the sweep at row 0 in the same manner as from IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE and drive vec_out=0, row_valid=0, row_idx=0, row_mismatch=0, mismatch_cnt=0, busy=0 and done=0, including mid-sweep.
REQ-033 After rst_n deasserts, the block SHALL stay in IDLE until start is accepted.

Verification (N_IN=4, N_OUT=3, SETTLE=2)
REQ-034 Reset: rst_n=0 pulsed between clock edges -> all outputs 0 without a clock edge.
REQ-035 Loopback: gold_out=dut_out, start for 1 cycle -> 16 row_valid pulses with row_idx 0..15, each 3 cycles apart; done after 48 cycles; mismatch_cnt=0.
REQ-036 Injected errors: gold_out differs from dut_out on rows 5 and 12 -> row_mismatch=1 only on those rows; final mismatch_cnt=2.
REQ-037 Abort: abort at row 7 in SETTLE -> next cycle busy=0, vec_out=0, done=0; a following start runs a fresh 16-row sweep.
REQ-038 Start handling: start held during a sweep -> no restart, exactly 16 rows published; start in DONE -> done clears and a new sweep begins at row 0.
REQ-039 Boundary: N_IN=1, SETTLE=1 -> rows 0..1, done after 4 cycles; all-mismatch case -> mismatch_cnt=2.
